// File: rtl/jtdd_io_pkg.sv
// Register map and bit positions shared by the jtdd main-board I/O block.
package jtdd_io_pkg;

   // Write-side register addresses
   localparam logic [3:0] ADDR_MISC   = 4'h0;
   localparam logic [3:0] ADDR_SCR0   = 4'h1;
   localparam logic [3:0] ADDR_SCR1   = 4'h2;
   localparam logic [3:0] ADDR_SND    = 4'h6;
   localparam logic [3:0] ADDR_IRQCLR = 4'h8;
   localparam logic [3:0] ADDR_MASK   = 4'hC;
   localparam logic [3:0] ADDR_OVFCLR = 4'hD;

   // Read-side register addresses
   localparam logic [3:0] ADDR_STATUS = 4'hE;
   localparam logic [3:0] ADDR_MASKRD = 4'hF;

   // Status register bit positions (pending occupies bits 3:0)
   localparam int ST_OVF   = 4;
   localparam int ST_FULL  = 5;
   localparam int ST_EMPTY = 6;

   // Misc register bit positions (bank occupies MISC_BANK upwards)
   localparam int MISC_SCR0H = 0;
   localparam int MISC_SCR1H = 1;
   localparam int MISC_FLIP  = 2;
   localparam int MISC_RSTB  = 3;
   localparam int MISC_HALT  = 4;
   localparam int MISC_BANK  = 5;

endpackage

// File: rtl/jtdd_sndfifo.sv
// First-word-fall-through sound command FIFO; head holds the last popped
// byte once the FIFO drains, and full-without-pop pushes are dropped.
module jtdd_sndfifo #(
   parameter int SNDAW = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic       empty,
   output logic       full,
   output logic       ovf_set
);
   localparam int              DEPTH    = 1 << SNDAW;
   localparam logic [SNDAW:0]  FULL_CNT = {1'b1, {SNDAW{1'b0}}};

   logic [7:0]       mem [DEPTH];
   logic [SNDAW-1:0] wr_ptr;
   logic [SNDAW-1:0] rd_ptr;
   logic [SNDAW:0]   count;
   logic [7:0]       last;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   // A pop from a full FIFO always frees a slot, so push+pop on full is legal
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign ovf_set = push & full & ~pop;
   assign head    = empty ? last : mem[rd_ptr];

   // Storage array carries no reset; visibility is governed by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers, occupancy and the held-last-value register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last   <= 8'h00;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last   <= mem[rd_ptr];
         end
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/jtdd_main_io.sv
// Main-CPU write registers, edge-latched masked interrupts and the sound
// command FIFO for the jtdd main board.
module jtdd_main_io
   import jtdd_io_pkg::*;
#(
   parameter int IRQW  = 3,
   parameter int BANKW = 3,
   parameter int SCRW  = 9,
   parameter int SNDAW = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cpu_cen,
   input  logic             cs,
   input  logic             RnW,
   input  logic [3:0]       addr,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   input  logic [IRQW-1:0]  irq_src,
   output logic [IRQW-1:0]  irq_n,
   output logic [SCRW-1:0]  scr0,
   output logic [SCRW-1:0]  scr1,
   output logic [BANKW-1:0] bank,
   output logic             flip,
   output logic             mcu_rstb,
   output logic             mcu_halt,
   output logic [7:0]       snd_latch,
   output logic             snd_irq,
   input  logic             snd_rd
);
   logic            we;
   logic            snd_push;
   logic [8:0]      scr0_r;
   logic [8:0]      scr1_r;
   logic [IRQW-1:0] mask;
   logic [IRQW-1:0] pending;
   logic [IRQW-1:0] src_prev;
   logic [IRQW-1:0] rise;
   logic [IRQW-1:0] irq_clr;
   logic            ovf;
   logic            ovf_set;
   logic            fifo_empty;
   logic            fifo_full;

   assign we       = cs & ~RnW & cpu_cen;
   assign snd_push = we && (addr == ADDR_SND);
   assign rise     = irq_src & ~src_prev;
   // With 8-bit scroll the stored high bits simply never reach the outputs
   assign scr0     = scr0_r[SCRW-1:0];
   assign scr1     = scr1_r[SCRW-1:0];
   assign snd_irq  = ~fifo_empty;

   // Decode per-channel pending-clear strobes
   always_comb begin
      irq_clr = '0;
      for (int i = 0; i < IRQW; i++)
         irq_clr[i] = we && (addr == ADDR_IRQCLR + 4'(i));
   end

   // CPU-writable control registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scr0_r   <= '0;
         scr1_r   <= '0;
         bank     <= '0;
         flip     <= 1'b0;
         mcu_rstb <= 1'b0;
         mcu_halt <= 1'b0;
         mask     <= '1;
      end else if (we) begin
         case (addr)
            ADDR_MISC: begin
               scr0_r[8] <= din[MISC_SCR0H];
               scr1_r[8] <= din[MISC_SCR1H];
               flip      <= din[MISC_FLIP];
               mcu_rstb  <= din[MISC_RSTB];
               mcu_halt  <= din[MISC_HALT];
               bank      <= din[MISC_BANK +: BANKW];
            end
            ADDR_SCR0: scr0_r[7:0] <= din;
            ADDR_SCR1: scr1_r[7:0] <= din;
            ADDR_MASK: mask        <= din[IRQW-1:0];
            default:   ;
         endcase
      end
   end

   // Edge capture, pending latch (set beats clear) and registered irq_n
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         src_prev <= '1;
         pending  <= '0;
         irq_n    <= '1;
      end else begin
         src_prev <= irq_src;
         pending  <= (pending & ~irq_clr) | rise;
         irq_n    <= ~(pending & mask);
      end
   end

   // Sticky sound FIFO overflow flag; a new overflow beats a clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                           ovf <= 1'b0;
      else if (ovf_set)                    ovf <= 1'b1;
      else if (we && addr == ADDR_OVFCLR)  ovf <= 1'b0;
   end

   // Combinational read-back mux
   always_comb begin
      dout = 8'hFF;
      if (cs && RnW) begin
         case (addr)
            ADDR_STATUS: begin
               dout           = 8'h00;
               dout[3:0]      = 4'(pending);
               dout[ST_OVF]   = ovf;
               dout[ST_FULL]  = fifo_full;
               dout[ST_EMPTY] = fifo_empty;
            end
            ADDR_MASKRD: dout = 8'(mask);
            default:     dout = 8'hFF;
         endcase
      end
   end

   jtdd_sndfifo #(.SNDAW(SNDAW)) u_sndfifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (snd_push),
      .pop     (snd_rd),
      .din     (din),
      .head    (snd_latch),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .ovf_set (ovf_set)
   );

endmodule

// File: tb/tb_jtdd_main_io.sv
// Bench for jtdd_main_io: directed scenarios plus random traffic against a
// queue-based behavioural model.
module tb_jtdd_main_io;
   localparam int IRQW  = 3;
   localparam int BANKW = 3;
   localparam int SCRW  = 9;
   localparam int SNDAW = 2;
   localparam int DEPTH = 1 << SNDAW;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cpu_cen = 1'b0;
   logic             cs = 1'b0;
   logic             RnW = 1'b1;
   logic [3:0]       addr = 4'h0;
   logic [7:0]       din = 8'h00;
   logic [7:0]       dout;
   logic [IRQW-1:0]  irq_src = '1;
   logic [IRQW-1:0]  irq_n;
   logic [SCRW-1:0]  scr0, scr1;
   logic [BANKW-1:0] bank;
   logic             flip, mcu_rstb, mcu_halt, snd_irq;
   logic [7:0]       snd_latch;
   logic             snd_rd = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [8:0]  m_scr0, m_scr1;
   logic [2:0]  m_bank, m_mask, m_pend, m_prev, m_irqn;
   logic        m_flip, m_rstb, m_halt, m_ovf;
   logic [7:0]  m_last;
   logic [7:0]  q[$];

   jtdd_main_io #(.IRQW(IRQW), .BANKW(BANKW), .SCRW(SCRW), .SNDAW(SNDAW)) dut (
      .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .cs(cs), .RnW(RnW),
      .addr(addr), .din(din), .dout(dout), .irq_src(irq_src), .irq_n(irq_n),
      .scr0(scr0), .scr1(scr1), .bank(bank), .flip(flip),
      .mcu_rstb(mcu_rstb), .mcu_halt(mcu_halt), .snd_latch(snd_latch),
      .snd_irq(snd_irq), .snd_rd(snd_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_scr0 = '0; m_scr1 = '0; m_bank = '0;
      m_flip = 0; m_rstb = 0; m_halt = 0;
      m_mask = '1; m_pend = '0; m_prev = '1; m_irqn = '1;
      m_ovf = 0; m_last = 8'h00;
      q.delete();
   endfunction

   function automatic void model_clock();
      logic       w;
      logic       popped;
      logic       ovf_hit;
      w = cs & ~RnW & cpu_cen;
      m_irqn = ~(m_pend & m_mask);
      for (int i = 0; i < IRQW; i++)
         if (w && addr == 4'(8 + i)) m_pend[i] = 1'b0;
      m_pend = m_pend | (irq_src & ~m_prev);
      m_prev = irq_src;
      if (w) begin
         case (addr)
            4'h0: begin
               m_scr0[8] = din[0]; m_scr1[8] = din[1]; m_flip = din[2];
               m_rstb = din[3]; m_halt = din[4]; m_bank = din[7:5];
            end
            4'h1: m_scr0[7:0] = din;
            4'h2: m_scr1[7:0] = din;
            4'hC: m_mask = din[2:0];
            default: ;
         endcase
      end
      popped  = snd_rd && q.size() > 0;
      ovf_hit = 1'b0;
      if (popped) m_last = q.pop_front();
      if (w && addr == 4'h6) begin
         if (q.size() == DEPTH) ovf_hit = 1'b1;
         else q.push_back(din);
      end
      if (w && addr == 4'hD) m_ovf = 1'b0;
      if (ovf_hit) m_ovf = 1'b1;
   endfunction

   function automatic logic [7:0] model_dout();
      if (!cs || !RnW) return 8'hFF;
      if (addr == 4'hE)
         return {1'b0, q.size() == 0, q.size() == DEPTH, m_ovf, 1'b0, m_pend};
      if (addr == 4'hF) return {5'b0, m_mask};
      return 8'hFF;
   endfunction

   task automatic check_all();
      chk("irq_n", irq_n, m_irqn);
      chk("scr0", scr0, m_scr0);
      chk("scr1", scr1, m_scr1);
      chk("misc", {bank, flip, mcu_rstb, mcu_halt}, {m_bank, m_flip, m_rstb, m_halt});
      chk("snd_latch", snd_latch, (q.size() > 0) ? q[0] : m_last);
      chk("snd_irq", snd_irq, q.size() > 0);
      if (!cs || RnW) chk("dout", dout, model_dout());
   endtask

   task automatic cycle(input logic c, input logic rnw, input logic [3:0] a,
                        input logic [7:0] d, input logic [2:0] src,
                        input logic rd, input logic cen);
      cs = c; RnW = rnw; addr = a; din = d; irq_src = src; snd_rd = rd; cpu_cen = cen;
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [2:0] src);
      cycle(1'b1, 1'b0, a, d, src, 1'b0, 1'b1);
   endtask

   task automatic rdreg(input logic [3:0] a, input logic [2:0] src);
      cycle(1'b1, 1'b1, a, 8'h00, src, 1'b0, 1'b1);
   endtask

   task automatic rand_phase(input int n);
      logic [3:0] a;
      logic [2:0] s;
      int         r;
      for (int k = 0; k < n; k++) begin
         r = $urandom_range(0, 9);
         if (r < 3)       a = 4'h6;
         else if (r == 3) a = 4'hE;
         else             a = 4'($urandom_range(0, 15));
         s = irq_src;
         if ($urandom_range(0, 3) == 0) s = s ^ 3'($urandom_range(1, 7));
         cycle($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, a,
               8'($urandom), s, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) != 0);
      end
   endtask

   initial begin
      // Reset with all sources held high
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      rdreg(4'hE, 3'b111);
      chk("rst_status", dout, 8'h40);
      chk("rst_irq_n", irq_n, 3'b111);
      rdreg(4'hF, 3'b111);
      chk("rst_mask", dout, 8'h07);

      // Control registers
      wr(4'h0, 8'h7D, 3'b111);
      wr(4'h1, 8'h34, 3'b111);
      chk("scr0_val", scr0, 9'h134);
      chk("scr1_hi", scr1[8], 1'b0);
      chk("misc_val", {bank, flip, mcu_rstb, mcu_halt}, {3'd3, 3'b111});
      wr(4'h2, 8'hA5, 3'b111);
      chk("scr1_val", scr1, 9'h0A5);

      // Interrupt edge, set-beats-clear, then a lone clear
      cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b000, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b010, 1'b0, 1'b1);
      rdreg(4'hE, 3'b010);
      chk("edge_irq_n", irq_n, 3'b101);
      chk("edge_status", dout, 8'h42);
      cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b000, 1'b0, 1'b1);
      wr(4'h9, 8'hFF, 3'b010);
      rdreg(4'hE, 3'b010);
      chk("set_wins", dout, 8'h42);
      wr(4'h9, 8'h00, 3'b010);
      rdreg(4'hE, 3'b010);
      chk("clr_irq_n", irq_n, 3'b111);
      chk("clr_status", dout, 8'h40);

      // Mask hides but keeps pending; unmask asserts on the next clock
      wr(4'hC, 8'h00, 3'b000);
      cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b001, 1'b0, 1'b1);
      rdreg(4'hE, 3'b000);
      chk("masked_irq_n", irq_n, 3'b111);
      chk("masked_status", dout, 8'h41);
      wr(4'hC, 8'h07, 3'b000);
      rdreg(4'hF, 3'b000);
      chk("unmask_irq_n", irq_n, 3'b110);
      chk("mask_rd", dout, 8'h07);
      wr(4'h8, 8'h00, 3'b000);
      rdreg(4'hE, 3'b000);

      // FIFO fill past full, then drain
      for (int i = 1; i <= 5; i++) wr(4'h6, 8'(i * 8'h11), 3'b000);
      rdreg(4'hE, 3'b000);
      chk("full_status", dout, 8'h30);
      chk("full_latch", snd_latch, 8'h11);
      for (int i = 1; i <= 4; i++) begin
         chk("pop_head", snd_latch, 8'(i * 8'h11));
         cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b000, 1'b1, 1'b1);
      end
      chk("drain_irq", snd_irq, 1'b0);
      chk("drain_latch", snd_latch, 8'h44);
      cycle(1'b0, 1'b1, 4'h0, 8'h00, 3'b000, 1'b1, 1'b1);
      chk("empty_pop_latch", snd_latch, 8'h44);

      // Push with pop on a full FIFO, then clear overflow
      for (int i = 1; i <= 4; i++) wr(4'h6, 8'(8'hA0 + i), 3'b000);
      cycle(1'b1, 1'b0, 4'h6, 8'h66, 3'b000, 1'b1, 1'b1);
      rdreg(4'hE, 3'b000);
      chk("pushpop_status", dout, 8'h30);
      chk("pushpop_head", snd_latch, 8'hA2);
      wr(4'hD, 8'h00, 3'b000);
      rdreg(4'hE, 3'b000);
      chk("ovf_clear", dout, 8'h20);

      // Write without cpu_cen must not land
      cycle(1'b1, 1'b0, 4'h1, 8'hEE, 3'b000, 1'b0, 1'b0);
      chk("no_cen", scr0, 9'h134);

      // Asynchronous reset in the middle of a clock period
      #3 rstn = 1'b0;
      #1;
      chk("arst_latch", snd_latch, 8'h00);
      chk("arst_irq", snd_irq, 1'b0);
      chk("arst_scr0", scr0, 9'h000);
      model_reset();
      check_all();
      @(posedge clk);
      #1 rstn = 1'b1;

      rand_phase(800);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global timeout guard
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
